// File: rtl/text_pkg.sv
// Shared constants and types for the text-mode pixel pipeline.
package text_pkg;

   localparam int GLYPH_W   = 8;
   localparam int GLYPH_H   = 16;
   localparam int TEXT_COLS = 80;
   localparam int TEXT_ROWS = 30;

   typedef struct packed {
      logic [3:0] r;
      logic [3:0] g;
      logic [3:0] b;
   } rgb12_t;

   typedef struct packed {
      logic [4:0] row;
      logic [6:0] col;
   } cell_t;

   // A cursor parked outside the 80x30 text area must never light a cell.
   function automatic logic cell_in_range(input cell_t c);
      return (int'(c.col) < TEXT_COLS) && (int'(c.row) < TEXT_ROWS);
   endfunction

endpackage

// File: rtl/blink_timer.sv
// Cursor blink timer: counts vsync falling edges and toggles blink_phase
// every BLINK_FRAMES frames.
module blink_timer
   import text_pkg::*;
#(
   parameter int unsigned BLINK_FRAMES = 30
)
(
   input  logic Clk,
   input  logic Reset_n,
   input  logic pix_en,
   input  logic vs_in,
   output logic blink_phase
);

   logic       r_vs_prev;
   logic [7:0] r_frame_cnt;
   logic       r_blink_phase;
   logic       w_vs_fall;

   assign w_vs_fall = r_vs_prev & ~vs_in;

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_vs_prev     <= 1'b1;
         r_frame_cnt   <= 8'd0;
         r_blink_phase <= 1'b0;
      end else if (pix_en) begin
         r_vs_prev <= vs_in;
         if (w_vs_fall) begin
            if (r_frame_cnt == 8'(BLINK_FRAMES - 1)) begin
               r_frame_cnt   <= 8'd0;
               r_blink_phase <= ~r_blink_phase;
            end else begin
               r_frame_cnt <= r_frame_cnt + 8'd1;
            end
         end
      end
   end

   assign blink_phase = r_blink_phase;

endmodule

// File: rtl/text_pixel_pipe.sv
// Text-mode pixel stage: font ROM address, glyph bit select, colour, cursor
// and blanking, with syncs delayed to match. Cursor blink under CURSOR_BLINK_EN.
module text_pixel_pipe
   import text_pkg::*;
#(
   parameter int unsigned BLINK_FRAMES = 30
)
(
   input  logic        Clk,
   input  logic        Reset_n,
   input  logic        pix_en,
   input  logic [9:0]  drawX,
   input  logic [9:0]  drawY,
   input  logic [7:0]  draw_code,
   input  logic        hs_in,
   input  logic        vs_in,
   input  logic        blank_n_in,
   input  logic [11:0] fg_rgb,
   input  logic [11:0] bg_rgb,
   input  logic [6:0]  cursor_col,
   input  logic [4:0]  cursor_row,
   output logic [10:0] glyph_addr,
   input  logic [7:0]  glyph_data,
   output logic [3:0]  red,
   output logic [3:0]  green,
   output logic [3:0]  blue,
   output logic        hs_out,
   output logic        vs_out,
   output logic        blank_n_out
);

   logic [10:0] r_glyph_addr;
   logic [2:0]  r_s1_col;
   logic        r_s1_inv;
   cell_t       r_s1_cell;
   logic        r_s1_hs;
   logic        r_s1_vs;
   logic        r_s1_blank_n;

   logic [2:0]  r_s2_col;
   logic        r_s2_inv;
   cell_t       r_s2_cell;
   logic        r_s2_hs;
   logic        r_s2_vs;
   logic        r_s2_blank_n;

   rgb12_t      r_rgb;
   logic        r_hs_out;
   logic        r_vs_out;
   logic        r_blank_n_out;

   logic        w_cursor_hit;
   logic        w_pix_bit;
   rgb12_t      w_rgb;
   logic        w_unused_drawy;

   assign w_unused_drawy = drawY[9];

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_glyph_addr <= '0;
         r_s1_col     <= '0;
         r_s1_inv     <= 1'b0;
         r_s1_cell    <= '0;
         r_s1_hs      <= 1'b1;
         r_s1_vs      <= 1'b1;
         r_s1_blank_n <= 1'b0;
      end else if (pix_en) begin
         r_glyph_addr <= {draw_code[6:0], drawY[3:0]};
         r_s1_col     <= drawX[2:0];
         r_s1_inv     <= draw_code[7];
         r_s1_cell    <= {drawY[8:4], drawX[9:3]};
         r_s1_hs      <= hs_in;
         r_s1_vs      <= vs_in;
         r_s1_blank_n <= blank_n_in;
      end
   end

   // Stage 2 only waits out the font ROM's registered read.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_s2_col     <= '0;
         r_s2_inv     <= 1'b0;
         r_s2_cell    <= '0;
         r_s2_hs      <= 1'b1;
         r_s2_vs      <= 1'b1;
         r_s2_blank_n <= 1'b0;
      end else if (pix_en) begin
         r_s2_col     <= r_s1_col;
         r_s2_inv     <= r_s1_inv;
         r_s2_cell    <= r_s1_cell;
         r_s2_hs      <= r_s1_hs;
         r_s2_vs      <= r_s1_vs;
         r_s2_blank_n <= r_s1_blank_n;
      end
   end

`ifdef CURSOR_BLINK_EN
   logic  w_blink_phase;
   cell_t w_cursor_cell;

   blink_timer #(
      .BLINK_FRAMES(BLINK_FRAMES)
   ) u_blink_timer (
      .Clk         (Clk),
      .Reset_n     (Reset_n),
      .pix_en      (pix_en),
      .vs_in       (vs_in),
      .blink_phase (w_blink_phase)
   );

   assign w_cursor_cell = {cursor_row, cursor_col};
   assign w_cursor_hit  = w_blink_phase && cell_in_range(w_cursor_cell) &&
                          (r_s2_cell == w_cursor_cell);
`else
   logic w_unused_cursor;

   assign w_unused_cursor = ^{cursor_col, cursor_row, vs_in, r_s2_cell, 8'(BLINK_FRAMES)};
   assign w_cursor_hit    = 1'b0;
`endif

   // Bit 7 of the glyph row is the leftmost pixel of the cell.
   assign w_pix_bit = glyph_data[3'd7 - r_s2_col] ^ r_s2_inv ^ w_cursor_hit;
   assign w_rgb     = !r_s2_blank_n ? rgb12_t'(12'h000) :
                      (w_pix_bit ? rgb12_t'(fg_rgb) : rgb12_t'(bg_rgb));

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_rgb         <= '0;
         r_hs_out      <= 1'b1;
         r_vs_out      <= 1'b1;
         r_blank_n_out <= 1'b0;
      end else if (pix_en) begin
         r_rgb         <= w_rgb;
         r_hs_out      <= r_s2_hs;
         r_vs_out      <= r_s2_vs;
         r_blank_n_out <= r_s2_blank_n;
      end
   end

   assign glyph_addr  = r_glyph_addr;
   assign red         = r_rgb.r;
   assign green       = r_rgb.g;
   assign blue        = r_rgb.b;
   assign hs_out      = r_hs_out;
   assign vs_out      = r_vs_out;
   assign blank_n_out = r_blank_n_out;

endmodule

// File: tb/tb_text_pixel_pipe.sv
// Scoreboard testbench for text_pixel_pipe; honours CURSOR_BLINK_EN for the
// blink expectations.
`timescale 1ns/1ps
module tb_text_pixel_pipe;

   localparam int BLINK = 2;

   logic        Clk = 1'b0;
   logic        Reset_n;
   logic        pix_en;
   logic [9:0]  drawX;
   logic [9:0]  drawY;
   logic [7:0]  draw_code;
   logic        hs_in;
   logic        vs_in;
   logic        blank_n_in;
   logic [11:0] fg_rgb;
   logic [11:0] bg_rgb;
   logic [6:0]  cursor_col;
   logic [4:0]  cursor_row;
   logic [10:0] glyph_addr;
   logic [7:0]  glyph_data;
   logic [3:0]  red;
   logic [3:0]  green;
   logic [3:0]  blue;
   logic        hs_out;
   logic        vs_out;
   logic        blank_n_out;

   typedef struct {
      logic [7:0] code;
      logic [9:0] x;
      logic [9:0] y;
      logic       hs;
      logic       vs;
      logic       bl;
      logic       phase;
   } pix_t;

   pix_t        q[$];
   logic [7:0]  rom [2048];
   int          falls;
   logic        prevVs;
   int          assertCount = 0;
   int          failCount = 0;
   logic [10:0] lastAddr;
   logic [11:0] lastRgb;
   logic        lastHs;
   logic        lastVs;
   logic        lastBl;

   text_pixel_pipe #(.BLINK_FRAMES(BLINK)) dut (
      .Clk         (Clk),
      .Reset_n     (Reset_n),
      .pix_en      (pix_en),
      .drawX       (drawX),
      .drawY       (drawY),
      .draw_code   (draw_code),
      .hs_in       (hs_in),
      .vs_in       (vs_in),
      .blank_n_in  (blank_n_in),
      .fg_rgb      (fg_rgb),
      .bg_rgb      (bg_rgb),
      .cursor_col  (cursor_col),
      .cursor_row  (cursor_row),
      .glyph_addr  (glyph_addr),
      .glyph_data  (glyph_data),
      .red         (red),
      .green       (green),
      .blue        (blue),
      .hs_out      (hs_out),
      .vs_out      (vs_out),
      .blank_n_out (blank_n_out)
   );

   always #10 Clk = ~Clk;

   // Synchronous font ROM: samples the address on enabled edges.
   always @(posedge Clk) begin
      if (pix_en) glyph_data <= rom[glyph_addr];
   end

   function automatic logic phaseOf(input int f);
`ifdef CURSOR_BLINK_EN
      return ((f / BLINK) % 2) == 1;
`else
      return 1'b0;
`endif
   endfunction

   // Reference pixel colour from the character-cell rules.
   function automatic logic [11:0] expRgb(input pix_t r);
      int         col     = int'(r.x) % 8;
      int         cellCol = int'(r.x) / 8;
      int         cellRow = (int'(r.y) / 16) % 32;
      logic [7:0] rowBits = rom[{r.code[6:0], r.y[3:0]}];
      logic       hit;
      logic       bitv;
      hit  = r.phase && (int'(cursor_col) < 80) && (int'(cursor_row) < 30) &&
             (cellCol == int'(cursor_col)) && (cellRow == int'(cursor_row));
      bitv = rowBits[7 - col] ^ r.code[7] ^ hit;
      if (!r.bl) return 12'h000;
      return bitv ? fg_rgb : bg_rgb;
   endfunction

   task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
      assertCount++;
      if (act !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic setIdleExpect();
      lastRgb = 12'h000;
      lastHs  = 1'b1;
      lastVs  = 1'b1;
      lastBl  = 1'b0;
   endtask

   // Issue one pixel on the next enabled edge, then hold pix_en low 1+extra cycles.
   task automatic applyStimulus(input logic [7:0] code, input logic [9:0] x, input logic [9:0] y,
                                input logic hs, input logic vs, input logic bl, input int extra);
      pix_t r;
      @(negedge Clk);
      draw_code  = code;
      drawX      = x;
      drawY      = y;
      hs_in      = hs;
      vs_in      = vs;
      blank_n_in = bl;
      pix_en     = 1'b1;
      if (prevVs && !vs) falls++;
      prevVs   = vs;
      r        = '{code, x, y, hs, vs, bl, phaseOf(falls)};
      q.push_back(r);
      lastAddr = {code[6:0], y[3:0]};
      @(negedge Clk);
      pix_en = 1'b0;
      repeat (extra) @(negedge Clk);
   endtask

   task automatic vsyncBlock();
      repeat (3) applyStimulus(8'h00, 10'd650, 10'd490, 1'b1, 1'b1, 1'b0, 0);
      repeat (4) applyStimulus(8'h00, 10'd650, 10'd491, 1'b1, 1'b0, 1'b0, 0);
      repeat (2) applyStimulus(8'h00, 10'd650, 10'd492, 1'b1, 1'b1, 1'b0, 0);
   endtask

   // Monitor: every enabled edge retires the pixel issued two enabled edges earlier.
   always @(posedge Clk) begin : monitor
      pix_t r;
      #1;
      if (Reset_n) begin
         if (pix_en) begin
            if (q.size() >= 3) begin
               r       = q.pop_front();
               lastRgb = expRgb(r);
               lastHs  = r.hs;
               lastVs  = r.vs;
               lastBl  = r.bl;
            end else begin
               setIdleExpect();
            end
         end
         checkOutput("rgb", 16'({red, green, blue}), 16'(lastRgb));
         checkOutput("syncs", 16'({hs_out, vs_out, blank_n_out}), 16'({lastHs, lastVs, lastBl}));
         checkOutput("glyph_addr", 16'(glyph_addr), 16'(lastAddr));
      end
   end

   initial begin : watchdog
      #500us;
      $display("[TB] FAIL watchdog: simulation did not complete in time");
      $fatal(1, "[TB] timeout");
   end

   initial begin : stimulus
      int cx;
      int cy;
      logic [9:0] x;
      logic [9:0] y;
      for (int i = 0; i < 2048; i++) rom[i] = 8'($urandom);
      rom[11'h415] = 8'h18;
      rom[11'h208] = 8'h00;

      Reset_n    = 1'b0;
      pix_en     = 1'b0;
      drawX      = '0;
      drawY      = '0;
      draw_code  = '0;
      hs_in      = 1'b1;
      vs_in      = 1'b1;
      blank_n_in = 1'b0;
      fg_rgb     = 12'hF84;
      bg_rgb     = 12'h15A;
      cursor_col = 7'd10;
      cursor_row = 5'd2;
      falls      = 0;
      prevVs     = 1'b1;
      lastAddr   = '0;
      setIdleExpect();

      repeat (3) @(negedge Clk);
      checkOutput("reset_rgb", 16'({red, green, blue}), 16'h000);
      checkOutput("reset_syncs", 16'({hs_out, vs_out, blank_n_out}), 16'b110);
      checkOutput("reset_addr", 16'(glyph_addr), 16'h000);
      Reset_n = 1'b1;

      repeat (3) applyStimulus(8'h00, 10'd700, 10'd10, 1'b1, 1'b1, 1'b0, 0);
      applyStimulus(8'h41, 10'd3, 10'd5, 1'b1, 1'b1, 1'b1, 0);
      applyStimulus(8'h41, 10'd0, 10'd5, 1'b1, 1'b1, 1'b1, 0);
      applyStimulus(8'hC1, 10'd3, 10'd5, 1'b1, 1'b1, 1'b1, 0);
      applyStimulus(8'hC1, 10'd0, 10'd5, 1'b1, 1'b1, 1'b1, 0);
      applyStimulus(8'h41, 10'd3, 10'd5, 1'b1, 1'b1, 1'b0, 0);

      applyStimulus(8'h41, 10'd3, 10'd5, 1'b1, 1'b1, 1'b1, 0);
      applyStimulus(8'h41, 10'd4, 10'd5, 1'b1, 1'b1, 1'b1, 4);
      applyStimulus(8'hC1, 10'd4, 10'd5, 1'b1, 1'b1, 1'b1, 4);

      for (int i = 0; i < 96; i++)
         applyStimulus(8'h33, 10'(656 + i), 10'd7, 1'b0, 1'b1, 1'b0, 0);
      repeat (4) applyStimulus(8'h33, 10'd760, 10'd7, 1'b1, 1'b1, 1'b0, 0);

      for (int f = 0; f < 6; f++) begin
         applyStimulus(8'h20, 10'd85, 10'd40, 1'b1, 1'b1, 1'b1, 0);
         applyStimulus(8'h20, 10'd80, 10'd47, 1'b1, 1'b1, 1'b1, 0);
         applyStimulus(8'h20, 10'd93, 10'd40, 1'b1, 1'b1, 1'b1, 0);
         vsyncBlock();
      end

      applyStimulus(8'h20, 10'd85, 10'd40, 1'b1, 1'b1, 1'b1, 0);
      applyStimulus(8'h41, 10'd3, 10'd5, 1'b1, 1'b1, 1'b1, 0);
      applyStimulus(8'h41, 10'd3, 10'd5, 1'b0, 1'b1, 1'b1, 0);
      @(posedge Clk);
      #4;
      Reset_n = 1'b0;
      pix_en  = 1'b0;
      vs_in   = 1'b1;
      #1;
      checkOutput("midreset_rgb", 16'({red, green, blue}), 16'h000);
      checkOutput("midreset_syncs", 16'({hs_out, vs_out, blank_n_out}), 16'b110);
      checkOutput("midreset_addr", 16'(glyph_addr), 16'h000);
      q.delete();
      falls    = 0;
      prevVs   = 1'b1;
      lastAddr = '0;
      setIdleExpect();
      repeat (3) @(negedge Clk);
      Reset_n = 1'b1;

      applyStimulus(8'h20, 10'd85, 10'd40, 1'b1, 1'b1, 1'b1, 0);
      applyStimulus(8'h20, 10'd86, 10'd41, 1'b1, 1'b1, 1'b1, 0);

      for (int i = 0; i < 300; i++) begin
         if (i % 60 == 59) vsyncBlock();
         if ($urandom_range(0, 9) == 0) fg_rgb = 12'($urandom);
         if ($urandom_range(0, 9) == 0) bg_rgb = 12'($urandom);
         if ($urandom_range(0, 19) == 0) begin
            cursor_col = 7'($urandom_range(0, 95));
            cursor_row = 5'($urandom_range(0, 31));
         end
         if ($urandom_range(0, 1) == 0) begin
            cx = int'(cursor_col) * 8 + int'($urandom_range(0, 15));
            cy = int'(cursor_row) * 16 + int'($urandom_range(0, 31));
            x  = 10'(cx);
            y  = 10'(cy);
         end else begin
            x = 10'($urandom);
            y = 10'($urandom);
         end
         applyStimulus(8'($urandom), x, y, ($urandom_range(0, 9) != 0), 1'b1,
                       ($urandom_range(0, 9) != 0), int'($urandom_range(0, 1)));
      end

      repeat (3) applyStimulus(8'h00, 10'd700, 10'd10, 1'b1, 1'b1, 1'b0, 0);
      repeat (2) @(negedge Clk);
      checkOutput("queue_drained", 16'(q.size()), 16'd2);
      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule

// File: doc/text_pixel_pipe.md
Name: text_pixel_pipe

Overview:
- Downstream stage of the text-mode character fetcher. Consumes the per-pixel character code (bit 7 = inverse video, bits 6:0 = glyph index) for the current drawX/drawY.
- Fetches the glyph row from a synchronous 8x16 font ROM and selects the pixel bit. Applies foreground/background colour, optional cursor blink, and blanking.
- Delays HS/VS/blank to match, then drives the VGA DAC outputs.

Parameters:
- GLYPH_W, 8, glyph width in pixels; fixed by the font.
- GLYPH_H, 16, glyph height in rows.
- BLINK_FRAMES, 30, number of frames per cursor blink half-period; legal range 1..255.

Ports:
- Clk  in  1  system clock, 50 MHz.
- Reset_n  in  1  asynchronous active-low reset.
- pix_en  in  1  pixel-clock enable; one Clk cycle in two.
- drawX  in  10  current pixel column.
- drawY  in  10  current pixel row.
- draw_code  in  8  character code for (drawX, drawY); combinationally valid with drawX/drawY.
- hs_in  in  1  horizontal sync, active-low, aligned with drawX.
- vs_in  in  1  vertical sync, active-low, aligned with drawX.
- blank_n_in  in  1  low = blanking interval.
- fg_rgb  in  12  foreground colour {R4,G4,B4}.
- bg_rgb  in  12  background colour {R4,G4,B4}.
- cursor_col  in  7  cursor cell column, 0..79.
- cursor_row  in  5  cursor cell row, 0..29.
- glyph_addr  out  11  font ROM address = {code[6:0], drawY[3:0]}.
- glyph_data  in  8  font ROM row data. Registered in the ROM on an enabled edge. Bit 7 = leftmost pixel.
- red  out  4  red DAC output.
- green  out  4  green DAC output.
- blue  out  4  blue DAC output.
- hs_out  out  1  delayed horizontal sync.
- vs_out  out  1  delayed vertical sync.
- blank_n_out  out  1  delayed blank.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- All registers advance only on Clk edges where pix_en=1. When pix_en=0, every register holds.
- Stage 1, enabled edge k:
  - glyph_addr <= {draw_code[6:0], drawY[3:0]}.
  - Capture col = drawX[2:0], inv = draw_code[7], cell = {drawY[8:4], drawX[9:3]}, hs, vs, blank_n.
- Font ROM: samples glyph_addr at edge k+1 and presents glyph_data after that edge. Stage 2 carries col/inv/cell/syncs alongside.
- Stage 3, edge k+2:
  - bit = glyph_data[7-col] XOR inv XOR cursor_hit.
  - rgb = bit ? fg_rgb : bg_rgb.
  - rgb is forced to 0 when the delayed blank_n is 0.
  - red/green/blue, hs_out, vs_out, blank_n_out all update together.
- Latency: exactly 2 enabled edges after the stage-1 edge, for pixel data and syncs alike.
- fg_rgb/bg_rgb are sampled at stage 3; no pipelining.
- Blink timer:
  - Detects a vs_in falling edge; the previous vs_in is registered on enabled edges.
  - On each falling edge, increment frame_cnt (8-bit).
  - When frame_cnt reaches BLINK_FRAMES-1, clear it to 0 and toggle blink_phase.
  - With BLINK_FRAMES=1, blink_phase toggles every frame.
- cursor_hit = blink_phase AND (cell == {cursor_row, cursor_col}).
- Boundaries:
  - drawX/drawY outside 640x480: addresses are computed anyway; output is masked by blank.
  - Cursor coordinates out of range (col > 79 or row > 29) never hit.
  - A vs falling edge that coincides with reset is ignored.
- Reset, asynchronous and at any point including mid-line:
  - red/green/blue = 0, glyph_addr = 0.
  - hs_out = vs_out = 1, blank_n_out = 0.
  - All pipeline valid/sync copies take their inactive values.
  - frame_cnt = 0, blink_phase = 0.
  - After release, outputs become meaningful from the third enabled edge.

Optional Feature:
- CURSOR_BLINK_EN defined: the blink timer and cursor_hit are built as described.
- CURSOR_BLINK_EN undefined:
  - The blink timer is removed and cursor_hit is constant 0.
  - cursor_col/cursor_row ports remain present and are ignored.
  - All other behaviour, including latency, is identical.

Decomposition:
- Package text_pkg:
  - Constants GLYPH_W=8, GLYPH_H=16, TEXT_COLS=80, TEXT_ROWS=30.
  - typedef rgb12_t (struct of three 4-bit fields).
  - typedef cell_t {row[4:0], col[6:0]}.
- Sub-module blink_timer:
  - Ports: Clk, Reset_n, pix_en, vs_in, blink_phase.
  - Instantiated only under CURSOR_BLINK_EN.

Test Plan:
- Address/decode: draw_code=0x41, drawY=5, drawX=3; ROM model returns 0x18. Expect glyph_addr=0x415 one edge later. Two edges later rgb=fg_rgb. With drawX=0, rgb=bg_rgb.
- Inverse: draw_code=0xC1, same row, drawX=3 → rgb=bg_rgb; drawX=0 → rgb=fg_rgb.
- Blank/sync alignment: drive blank_n_in=0 with glyph bit=1 → rgb=0x000. Pulse hs_in low for 96 pixels → hs_out low for exactly 96 enabled edges, delayed by 2 edges.
- pix_en hold: drop pix_en for 5 Clk cycles mid-line → all outputs and glyph_addr are unchanged.
- Blink (CURSOR_BLINK_EN, BLINK_FRAMES=2): cursor at (col 10, row 2), blank glyph, pixel (85,40).
  - rgb = bg for frames 0–1, fg for frames 2–3, bg for frames 4–5.
  - Without the macro: bg in all frames.
- Reset mid-line: assert Reset_n=0 asynchronously between edges → immediately rgb=0, hs_out=vs_out=1, blank_n_out=0, blink_phase=0.
